sumador_serial: RTL
===================

# sumador_serial

Parametrised bit-serial N-bit adder. It is the next step after the combinational 1-bit full adder: it reuses one full-adder cell over WIDTH clock cycles, LSB first, behind a start/busy/done handshake. It produces the registered N-bit sum, carry-out and signed overflow. It sits between operand registers and any consumer that can tolerate WIDTH-cycle latency in exchange for minimal adder area.

## Interface
Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..32

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result registers valid
- sum  output  WIDTH  registered sum
- cout  output  1  registered carry-out
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB)

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> latch a, b, cin into shift/carry registers, clear bit counter, go to RUN. start=0 -> stay.
  - RUN: each edge adds bit 0 of the A/B shift registers with the carry register through the full-adder cell. The sum bit shifts into the MSB of the result shift register, A/B shift right, the carry register takes the cell carry, and the counter increments. On the edge that processes bit WIDTH-1 -> go to DONE.
  - DONE: one cycle. start=1 -> accept new operands exactly as in IDLE and go to RUN (back-to-back). Otherwise go to IDLE.
- Entering DONE loads sum, cout and overflow from the completed internal result.
  - overflow uses the carry into bit WIDTH-1, which is the previous carry register value on the last bit.
  - For WIDTH=1, the carry into the MSB is cin.
- sum, cout and overflow hold their value until the next DONE entry. They do not toggle during RUN.
- start in RUN is ignored. Operand changes after capture are ignored.
- Counter width: $clog2(WIDTH), minimum 1 bit. The counter never wraps past WIDTH-1.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, internal shift/carry/counter=0.
- Reset has priority over everything, including mid-RUN. An in-flight operation is discarded, no done pulse is produced, and held outputs clear to 0.
- start sampled at edge k in IDLE:
  - busy=1 after edge k.
  - Bits processed at edges k+1 .. k+WIDTH.
  - After edge k+WIDTH: busy=0, done=1, and sum/cout/overflow are valid.
  - done returns to 0 after edge k+WIDTH+1.
- Throughput with back-to-back start: one result every WIDTH+1 cycles.
- busy and done are never high together.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package/include sumador_pkg:
  - state encoding localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - WIDTH_MAX=32
- Sole sub-module: the existing 1-bit full-adder cell sumador1bit (a, b, cin -> sum, cout), instantiated once.
- Everything else (FSM, counter, shift registers, carry register, output registers) lives in sumador_serial.

## Test plan
- WIDTH=8, a=0x7F, b=0x01, cin=0, start pulse -> done exactly 8 edges after the start edge; sum=0x80, cout=0, overflow=1.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1, overflow=0.
- WIDTH=8, start held high continuously with a=0x10, b=0x20 -> done pulses every 9 cycles; sum=0x30; start during busy never restarts the operation.
- WIDTH=8, rst_n=0 for one edge during RUN (after 4 bits) -> busy=0, sum=0, no done pulse. A following start with a=3, b=4 -> sum=7.
- WIDTH=1, all 8 (a, b, cin) combinations -> sum/cout match the full-adder truth table; done 1 edge after start; overflow = cin XOR cout.
- WIDTH=32, a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0, cout=1, overflow=0, done 32 edges after start.

Source files
------------

// File: rtl/sumador_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// widest operand the serial adder is meant to be built with.
package sumador_pkg;

   localparam int WIDTH_MAX = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sumador1bit.sv
// Combinational 1-bit full-adder cell; the serial adder reuses one of these
// for every bit position.
module sumador1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic w_p;

   assign w_p  = a ^ b;
   assign sum  = w_p ^ cin;
   assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/sumador_serial.sv
// Bit-serial WIDTH-bit adder: one full-adder cell walks the operands LSB
// first over WIDTH cycles behind a start/busy/done handshake. The sum,
// carry-out and signed overflow are registered and held between results.
module sumador_serial
   import sumador_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic             w_s;
   logic             w_c;
   logic             w_accept;
   logic             w_cnt_last;
   logic [WIDTH-1:0] w_res_full;

   // New operands are taken whenever the FSM is free (IDLE or DONE).
   assign w_accept   = start && (r_state == IDLE || r_state == DONE);
   assign w_cnt_last = (r_cnt == CW'(WIDTH - 1));

   sumador1bit u_cell (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .cin  (r_carry),
      .sum  (w_s),
      .cout (w_c)
   );

   // Result shift register: the newest sum bit enters at the MSB, so after
   // WIDTH shifts the first bit computed has reached bit 0. w_res_full is
   // the complete result as it stands after the current cell output.
   generate
      if (WIDTH == 1) begin : g_res1
         assign w_res_full = w_s;
      end else begin : g_resn
         logic [WIDTH-2:0] r_res;

         // Collect sum bits while running; cleared on reset and on accept.
         always_ff @(posedge clk) begin
            if (!rst_n)                r_res <= '0;
            else if (w_accept)         r_res <= '0;
            else if (r_state == RUN)   r_res <= w_res_full[WIDTH-1:1];
         end

         assign w_res_full = {w_s, r_res};
      end
   endgenerate

   // State register.
   // NOTE: clocked state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic.
   // NOTE: the default assignment first guarantees every path drives
   // w_state_next, so no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = RUN;
         RUN:     if (w_cnt_last) w_state_next = DONE;
         DONE:    w_state_next = start ? RUN : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Operand shift registers, carry, bit counter and held result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= b;
         r_carry <= cin;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_carry <= w_c;
         if (!w_cnt_last) begin
            r_cnt <= r_cnt + CW'(1);
         end else begin
            // Last bit: r_carry is the carry into the MSB.
            r_sum  <= w_res_full;
            r_cout <= w_c;
            r_ovf  <= r_carry ^ w_c;
         end
      end
   end

   assign busy     = (r_state == RUN);
   assign done     = (r_state == DONE);
   assign sum      = r_sum;
   assign cout     = r_cout;
   assign overflow = r_ovf;

endmodule
